// File: rtl/fifo_rd_fwft_pkg.sv
// Shared async-FIFO package: stage-wide width defaults and FWFT output-buffer sizing.
// Helpers here are used by both the read output stage and its 2-entry buffer.
package fifo_rd_fwft_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned ADDR_WIDTH = 4;

  // Output buffer depth; the issue rule keeps buffered + in-flight words within this.
  localparam int unsigned FWFT_DEPTH = 2;
  localparam int unsigned CNT_WIDTH  = $clog2(FWFT_DEPTH + 1);
  localparam int unsigned SUM_WIDTH  = CNT_WIDTH + 1;

  typedef logic [CNT_WIDTH-1:0] fwft_cnt_t;
  typedef logic [SUM_WIDTH-1:0] fwft_sum_t;

  // Words that will occupy the buffer after this edge; pop implies count >= 1.
  function automatic fwft_sum_t fwft_occupancy(input fwft_cnt_t count,
                                               input logic      add,
                                               input logic      sub);
    return SUM_WIDTH'(count) + SUM_WIDTH'(add) - SUM_WIDTH'(sub);
  endfunction

  // Buffer slot that a word written this cycle lands in, after any pop shift.
  function automatic fwft_cnt_t fwft_write_slot(input fwft_cnt_t count,
                                                input logic      sub);
    return count - CNT_WIDTH'(sub);
  endfunction

endpackage

// File: rtl/fifo_rd_fwft_skid_buf2.sv
// Two-entry in-order buffer: head in slot 0, pop shifts slot 1 forward,
// push writes at the first free slot after that shift.
module fifo_rd_fwft_skid_buf2
  import fifo_rd_fwft_pkg::*;
#(
  parameter int unsigned DW = fifo_rd_fwft_pkg::DATA_WIDTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic [DW-1:0]   data_in,
  input  logic            pop,
  output logic [DW-1:0]   head,
  output fwft_cnt_t       count,
  output logic            valid
);

  logic [DW-1:0] slot0;
  logic [DW-1:0] slot1;
  logic [DW-1:0] slot0_next;
  logic [DW-1:0] slot1_next;
  fwft_cnt_t     count_next;
  fwft_cnt_t     wr_slot;
  fwft_sum_t     occ_next;
  logic          valid_next;

  // Next contents: pop shift first, then the incoming word at the post-shift slot.
  always_comb begin
    slot0_next = slot0;
    slot1_next = slot1;
    occ_next   = fwft_occupancy(count, push, pop);
    wr_slot    = fwft_write_slot(count, pop);

    if (pop && (count == CNT_WIDTH'(2))) begin
      slot0_next = slot1;
    end

    if (push) begin
      if (wr_slot == CNT_WIDTH'(0)) begin
        slot0_next = data_in;
      end else begin
        slot1_next = data_in;
      end
    end

    count_next = CNT_WIDTH'(occ_next);
    valid_next = (occ_next != SUM_WIDTH'(0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= '0;
      valid <= 1'b0;
    end else begin
      slot0 <= slot0_next;
      slot1 <= slot1_next;
      count <= count_next;
      valid <= valid_next;
    end
  end

  assign head = slot0;

endmodule

// File: rtl/fifo_rd_fwft.sv
// Read-side FWFT output stage of the async FIFO: issues reads into the pointer
// logic and buffers the one-cycle-late memory data as a valid/ready stream.
module fifo_rd_fwft
  import fifo_rd_fwft_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = fifo_rd_fwft_pkg::DATA_WIDTH
) (
  input  logic                  rclk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  rinc,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready
);

  logic      inflight;
  logic      pop;
  fwft_cnt_t count;
  fwft_sum_t occ_after;

  assign pop = m_valid & m_ready;

  // Only issue when the word returning next cycle is guaranteed a free slot.
  assign occ_after = fwft_occupancy(count, inflight, pop);
  assign rinc      = ~fifo_empty & (occ_after < SUM_WIDTH'(FWFT_DEPTH));

  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
    end else begin
      inflight <= rinc;
    end
  end

  fifo_rd_fwft_skid_buf2 #(
    .DW (DATA_WIDTH)
  ) u_skid_buf2 (
    .clk     (rclk),
    .rst_n   (rst_n),
    .push    (inflight),
    .data_in (fifo_rdata),
    .pop     (pop),
    .head    (m_data),
    .count   (count),
    .valid   (m_valid)
  );

endmodule

// File: tb/tb_fifo_rd_fwft.sv
// Bench for fifo_rd_fwft: queue-based FIFO/stage model checked every cycle,
// plus directed latency, throughput, backpressure, reset and drain cases.
module tb_fifo_rd_fwft;

  localparam int unsigned DW = 8;

  logic          rclk = 1'b0;
  logic          rst_n = 1'b1;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rdata;
  logic          rinc;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;

  always #5 rclk = ~rclk;

  fifo_rd_fwft #(.DATA_WIDTH(DW)) dut (
    .rclk       (rclk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .rinc       (rinc),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int issued = 0;
  int delivered = 0;
  int first_dcyc = -1;
  int last_dcyc = -1;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] sb_q[$];
  logic [DW-1:0] m_q[$];
  logic          m_inflight = 1'b0;
  logic [DW-1:0] m_inflight_word = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic load(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    sb_q.push_back(w);
  endtask

  task automatic refresh_empty();
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic new_phase();
    delivered  = 0;
    issued     = 0;
    first_dcyc = -1;
    last_dcyc  = -1;
  endtask

  // One clock: compare at negedge against the model, then advance model and FIFO.
  task automatic cycle();
    logic          exp_valid;
    logic          exp_pop;
    logic          exp_rinc;
    logic [DW-1:0] nxt;
    int            occ;
    @(negedge rclk);
    exp_valid = (m_q.size() != 0);
    exp_pop   = exp_valid && m_ready;
    occ       = m_q.size() + int'(m_inflight) - int'(exp_pop);
    exp_rinc  = !fifo_empty && (occ < 2);
    chk("m_valid", 32'(m_valid), 32'(exp_valid));
    if (exp_valid) chk("m_data", 32'(m_data), 32'(m_q[0]));
    chk("rinc", 32'(rinc), 32'(exp_rinc));
    if (m_valid && m_ready) begin
      delivered++;
      if (first_dcyc < 0) first_dcyc = cyc;
      last_dcyc = cyc;
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL order: got %0h expected no word (cycle %0d)", m_data, cyc);
      end else begin
        chk("order", 32'(m_data), 32'(sb_q.pop_front()));
      end
    end
    nxt = fifo_rdata;
    if (rinc && (fifo_q.size() != 0)) begin
      nxt = fifo_q.pop_front();
      issued++;
    end
    if (exp_pop) void'(m_q.pop_front());
    if (m_inflight) m_q.push_back(m_inflight_word);
    m_inflight      = exp_rinc;
    m_inflight_word = nxt;
    @(posedge rclk);
    #1;
    cyc++;
    fifo_rdata = nxt;
    refresh_empty();
  endtask

  task automatic run_until(input int target, input int budget, input string name);
    int n;
    n = 0;
    while ((delivered < target) && (n < budget)) begin
      cycle();
      n++;
    end
    checks++;
    if (delivered < target) begin
      failures++;
      $display("FAIL %s_timeout: got %0d words expected %0d", name, delivered, target);
    end
  endtask

  task automatic model_reset();
    fifo_q.delete();
    sb_q.delete();
    m_q.delete();
    m_inflight = 1'b0;
    m_inflight_word = '0;
    fifo_empty = 1'b1;
    fifo_rdata = '0;
  endtask

  // Structural invariants sampled away from the clock edge.
  always @(negedge rclk) begin
    if (rst_n) begin
      a_count: assert (dut.count <= 2'd2)
        else begin
          failures++;
          $display("FAIL count_le2: got %0d expected <=2", dut.count);
        end
      a_rinc: assert (!(rinc && fifo_empty))
        else begin
          failures++;
          $display("FAIL rinc_when_empty: got rinc=1 expected 0");
        end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    m_ready = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b0;
    #1;
    // Test 1: reset values
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_rinc", 32'(rinc), 32'd0);
    repeat (2) @(posedge rclk);
    #1;
    rst_n = 1'b1;

    // Test 2: single-word latency
    new_phase();
    m_ready = 1'b1;
    load(8'h11);
    fifo_empty = 1'b0;
    #1;
    chk("t2_rinc_cycN", 32'(rinc), 32'd1);
    cycle();
    cycle();
    chk("t2_valid_N1", 32'(m_valid), 32'd1);
    chk("t2_data_N1", 32'(m_data), 32'h11);
    chk("t2_rinc_after", 32'(rinc), 32'd0);
    repeat (2) cycle();

    // Test 3: back-to-back streaming
    new_phase();
    for (int i = 1; i <= 16; i++) load(8'(i));
    refresh_empty();
    m_ready = 1'b1;
    run_until(16, 60, "t3");
    chk("t3_issued", 32'(issued), 32'd16);
    chk("t3_gapless", 32'(last_dcyc - first_dcyc), 32'd15);
    repeat (2) cycle();

    // Test 4: backpressure fills buffer, then drains in order
    new_phase();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) load(8'(8'h21 + i));
    refresh_empty();
    repeat (6) cycle();
    chk("t4_issued_held", 32'(issued), 32'd2);
    chk("t4_rinc_full", 32'(rinc), 32'd0);
    chk("t4_valid_held", 32'(m_valid), 32'd1);
    chk("t4_data_held", 32'(m_data), 32'h21);
    chk("t4_count_full", 32'(dut.count), 32'd2);
    m_ready = 1'b1;
    run_until(4, 30, "t4");
    chk("t4_issued_all", 32'(issued), 32'd4);
    repeat (2) cycle();

    // Test 1b: asynchronous reset with a full buffer
    new_phase();
    m_ready = 1'b0;
    load(8'h31);
    load(8'h32);
    load(8'h33);
    refresh_empty();
    repeat (4) cycle();
    chk("t1b_count_pre", 32'(dut.count), 32'd2);
    #2;
    model_reset();
    rst_n = 1'b0;
    #1;
    chk("t1b_valid_async", 32'(m_valid), 32'd0);
    chk("t1b_data_async", 32'(m_data), 32'd0);
    chk("t1b_rinc_async", 32'(rinc), 32'd0);
    @(posedge rclk);
    #1;
    rst_n = 1'b1;
    repeat (2) cycle();

    // Test 5: random backpressure over 200 words
    new_phase();
    for (int i = 0; i < 200; i++) load(8'(i));
    refresh_empty();
    begin
      int n;
      n = 0;
      while ((delivered < 200) && (n < 2000)) begin
        m_ready = ($urandom_range(0, 2) != 0);
        cycle();
        n++;
      end
    end
    chk("t5_delivered", 32'(delivered), 32'd200);
    chk("t5_sb_empty", 32'(sb_q.size()), 32'd0);
    m_ready = 1'b1;
    repeat (3) cycle();

    // Test 6: FIFO goes empty with one buffered and one in-flight word
    new_phase();
    m_ready = 1'b1;
    load(8'hA5);
    load(8'h5A);
    refresh_empty();
    run_until(2, 20, "t6");
    chk("t6_consecutive", 32'(last_dcyc - first_dcyc), 32'd1);
    repeat (2) cycle();
    chk("t6_valid_idle", 32'(m_valid), 32'd0);
    chk("t6_rinc_idle", 32'(rinc), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_rd_fwft.md
Name: fifo_rd_fwft

Overview:
- Read-side output stage of the async FIFO, in the read clock domain, directly downstream of the read-pointer/empty logic.
- Drives `rinc` into the pointer logic and takes `empty` from it.
- Captures the memory read data, which arrives one cycle after an accepted read.
- Presents it as a first-word-fall-through valid/ready stream through a 2-entry output buffer, sustaining 1 word/cycle.

Parameters:
- `DATA_WIDTH`, 8, width of the FIFO word and of `m_data`.

Ports:
- `rclk`  in  1  read-domain clock; all state on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `fifo_empty`  in  1  registered empty flag from the read-pointer logic.
- `fifo_rdata`  in  DATA_WIDTH  memory read data; valid in the cycle after a read is accepted.
- `rinc`  out  1  read request to the read-pointer logic; combinational.
- `m_valid`  out  1  output word valid.
- `m_data`  out  DATA_WIDTH  output word (buffer head).
- `m_ready`  in  1  downstream consumer accepts `m_data` when `m_valid` & `m_ready`.

Behaviour:
- Reset (async, `rst_n`=0): `count`=0, `inflight`=0, both buffer entries=0, so `m_valid`=0 and `m_data`=0. `rinc` is 0 whenever `fifo_empty`=1, which holds during reset.
- State:
  - `inflight`: 1 bit, a read was accepted last cycle.
  - `count`: 0..2, words held in the buffer.
  - `buf[0]` (head) and `buf[1]`.
- `pop` = `m_valid` & `m_ready`. `m_valid` = (`count`!=0). `m_data` = `buf[0]`.
- Issue rule: `rinc` = !`fifo_empty` & ((`count` + `inflight` - `pop`) < 2).
  - Sums are computed 3 bits wide; the term never underflows because `pop` implies `count`>=1.
- Accepted read: `fire` = `rinc` (already gated by !`fifo_empty`). Next cycle `inflight` <= `fire`.
- Capture: when `inflight`=1, `fifo_rdata` is written to the buffer this cycle:
  - into slot `count` - `pop` after the pop shift;
  - with `count`=0, or `count`=1 & `pop`, it lands in `buf[0]`.
- Pop: `buf[0]` <= `buf[1]` when `count`=2.
- `count_next` = `count` + `inflight` - `pop`.
- Simultaneous capture and pop: both occur; `count` is unchanged.
- Latency: `fifo_empty` falls before edge N → `rinc`=1 in cycle N → `m_valid`=1 after edge N+1, with that word on `m_data`.
- Throughput: with `m_ready` held 1 and FIFO non-empty, `count`=1 and `inflight`=1 in steady state; `rinc` stays 1 and one word moves per cycle.
- Backpressure:
  - While `m_valid`=1 & `m_ready`=0, `m_data` and `m_valid` hold stable.
  - `count` + `inflight` never exceeds 2, so no overflow or data loss is possible.
- `count` = 2 with no pop: `rinc`=0.
- `count` = 1 and `inflight`=1 with no pop: `rinc`=0; the arriving word fills `buf[1]`.
- `fifo_empty`=1: `rinc`=0; buffered words still drain normally.
- Reset mid-operation: buffered and in-flight words are discarded. The read pointer resets in the same event, so FIFO and stage stay consistent.
- Illegal states are not reachable:
  - `count`=3;
  - `inflight` with `count`=2 and no pop.
- Assertions required in the bench:
  - `count` <= 2;
  - !(`rinc` & `fifo_empty`).

Decomposition:
- Shared FIFO package: `FWFT_DEPTH`=2, plus the common `DATA_WIDTH`/`ADDR_WIDTH` defaults used by all FIFO stages.
- One natural sub-module: `skid_buf2`, the 2-entry buffer. It has push/data_in, pop, head and count outputs.
- `fifo_rd_fwft` keeps the issue rule and the `inflight` register.

Test Plan:
1. Reset with `fifo_empty`=1 → `m_valid`=0, `m_data`=0, `rinc`=0. Assert `rst_n` mid-stream with `count`=2 → `m_valid`=0 immediately (async).
2. FIFO holds 0x11, `fifo_empty` falls, `m_ready`=1 → `rinc`=1 at cycle N; `m_valid`=1 with `m_data`=0x11 at N+1; model drops empty after one read → `rinc`=0.
3. Stream 0x01..0x10 with `m_ready`=1 and FIFO never empty → `rinc` high every cycle after the first; 16 consecutive `m_valid` cycles carry data in order, no gaps.
4. Hold `m_ready`=0 with FIFO non-empty → exactly 2 reads issued; `count`=2, `rinc`=0; `m_data`=first word stays stable. Raise `m_ready` → words delivered in order, reads resume.
5. Toggle `m_ready` randomly 1-in-3 over 200 words (0x00..0xC7) → scoreboard matches in order; no overflow; `count`<=2 and !(`rinc` & `fifo_empty`) never fire.
6. `fifo_empty` rises while `count`=1 and `inflight`=1, `m_ready`=1 → both words (e.g. 0xA5, 0x5A) delivered on consecutive cycles; then `m_valid`=0 and `rinc`=0.
